jtopl_sh_ram: RTL and testbench

- RAM-based, parametrised successor to the flip-flop delay line used for per-slot operator state in the OPL pipeline.
- Delays a WIDTH-bit word by STAGES clock-enable ticks, using a circular buffer instead of STAGES×WIDTH flops. This lets long operator chains (18/36 slots) map to distributed/block RAM.
- Adds behaviour the flop version lacks:
  - a real reset sweep that clears every stored slot to RSTVAL;
  - a ready flag;
  - a hold (recirculate) mode that keeps a slot's value instead of loading din.

---
 rtl/jtopl_sh_ram_if.sv | 14 +
 rtl/jtopl_sh_ram.sv | 100 ++++++++++
 tb/tb_jtopl_sh_ram.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_sh_ram_if.sv
// Pipeline-side signal bundle for the RAM-based operator delay line.
// The master drives the tick/data inputs; the slave (delay line) returns drop/ready.
interface jtopl_sh_ram_if #(
  parameter int WIDTH = 5
) ();
  logic             cen;
  logic [WIDTH-1:0] din;
  logic             hold;
  logic [WIDTH-1:0] drop;
  logic             ready;

  modport master (output cen, output din, output hold, input drop, input ready);
  modport slave  (input cen, input din, input hold, output drop, output ready);
endinterface

// File: rtl/jtopl_sh_ram.sv
// Circular-buffer delay line: a WIDTH-bit word is delayed by STAGES cen ticks using
// DEPTH = STAGES-1 RAM words plus one output register, with a reset-time clear sweep.
module jtopl_sh_ram #(
  parameter int               WIDTH  = 5,
  parameter int               STAGES = 18,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  jtopl_sh_ram_if.slave  bus
);

  localparam int DEPTH = STAGES - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0] drop_q, drop_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_data;

  // Asynchronous read registered into drop_q: the write below lands after the read,
  // so a same-address read-during-write always sees the old word.
  assign rd_data = mem[ptr_q];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    drop_d    = drop_q;
    we        = 1'b0;
    waddr     = clr_cnt_q;
    wdata     = RSTVAL;

    case (state_q)
      ST_CLEAR: begin
        we        = 1'b1;
        drop_d    = RSTVAL;
        clr_cnt_d = clr_cnt_q + ONE;
        if (clr_cnt_q == LAST) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      default: begin
        if (bus.cen) begin
          drop_d = rd_data;
          we     = 1'b1;
          waddr  = ptr_q;
          wdata  = bus.hold ? rd_data : bus.din;
          ptr_d  = (ptr_q == LAST) ? '0 : ptr_q + ONE;
        end
      end
    endcase

    // Reset overrides everything, including a coincident cen tick.
    if (rst) we = 1'b0;
  end

  assign ready_d = (state_d == ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      clr_cnt_q <= '0;
      drop_q    <= RSTVAL;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      drop_q    <= drop_d;
      ready_q   <= ready_d;
    end
  end

  // NOTE: the RAM has no reset branch so it can map to RAM primitives; the CLEAR sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.drop  = drop_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_jtopl_sh_ram.sv
// Self-checking bench: three delay lines (STAGES 18/3/10) share stimulus and are compared
// every cycle against a tick-history model of an ideal STAGES-deep shift register.
module tb_jtopl_sh_ram;

  localparam int W = 5;
  localparam int N = 3;
  localparam int ST0 = 18;
  localparam int ST1 = 3;
  localparam int ST2 = 10;
  localparam logic [W-1:0] RV0 = 5'h1F;
  localparam logic [W-1:0] RV1 = 5'h15;
  localparam logic [W-1:0] RV2 = 5'h00;
  localparam int HIST = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  = 1'b1;
  logic         cen  = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] din  = '0;

  jtopl_sh_ram_if #(.WIDTH(W)) bus0 ();
  jtopl_sh_ram_if #(.WIDTH(W)) bus1 ();
  jtopl_sh_ram_if #(.WIDTH(W)) bus2 ();

  assign bus0.cen = cen;  assign bus0.din = din;  assign bus0.hold = hold;
  assign bus1.cen = cen;  assign bus1.din = din;  assign bus1.hold = hold;
  assign bus2.cen = cen;  assign bus2.din = din;  assign bus2.hold = hold;

  jtopl_sh_ram #(.WIDTH(W), .STAGES(ST0), .RSTVAL(RV0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  jtopl_sh_ram #(.WIDTH(W), .STAGES(ST1), .RSTVAL(RV1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  jtopl_sh_ram #(.WIDTH(W), .STAGES(ST2), .RSTVAL(RV2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [W-1:0] act_drop  [N];
  logic         act_ready [N];
  assign act_drop[0] = bus0.drop;  assign act_ready[0] = bus0.ready;
  assign act_drop[1] = bus1.drop;  assign act_ready[1] = bus1.ready;
  assign act_drop[2] = bus2.drop;  assign act_ready[2] = bus2.ready;

  // Reference: a word written on tick t is what the ideal line emits DEPTH ticks later.
  int           depth     [N];
  logic [W-1:0] rstval    [N];
  int           clr_cyc   [N];
  bit           run       [N];
  int           tcnt      [N];
  logic [W-1:0] wr_hist   [N][HIST];
  logic [W-1:0] exp_drop  [N];
  logic         exp_ready [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cyc(input logic r, input logic c, input logic [W-1:0] d, input logic h);
    logic [W-1:0] rd;
    @(negedge clk);
    rst = r; cen = c; din = d; hold = h;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        run[i] = 1'b0; clr_cyc[i] = 0; tcnt[i] = 0;
        exp_drop[i] = rstval[i]; exp_ready[i] = 1'b0;
      end else if (!run[i]) begin
        clr_cyc[i]++;
        if (clr_cyc[i] == depth[i]) begin
          run[i] = 1'b1; exp_ready[i] = 1'b1;
        end
      end else if (c) begin
        rd = (tcnt[i] >= depth[i]) ? wr_hist[i][tcnt[i] - depth[i]] : rstval[i];
        exp_drop[i] = rd;
        if (tcnt[i] < HIST) wr_hist[i][tcnt[i]] = h ? rd : d;
        tcnt[i]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    repeat (ST0 - 1) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) begin
      cyc(1'b1, 1'b1, W'($urandom), 1'b0);
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (act_drop[i] !== exp_drop[i] || act_ready[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset dut%0d: drop=%h ready=%b expected drop=%h ready=0",
                   i, act_drop[i], act_ready[i], exp_drop[i]);
        end
      end
    end
  endtask

  task automatic test_clear_sweep();
    int first_ready = -1;
    for (int j = 1; j <= 20; j++) begin
      cyc(1'b0, 1'($urandom), W'($urandom), 1'($urandom));
      if (first_ready < 0 && act_ready[0] === 1'b1) first_ready = j;
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (act_drop[i] !== exp_drop[i] || act_ready[i] !== exp_ready[i]) begin
          n_fail++;
          $display("FAIL clear dut%0d cyc%0d: drop=%h ready=%b expected drop=%h ready=%b",
                   i, j, act_drop[i], act_ready[i], exp_drop[i], exp_ready[i]);
        end
      end
    end
    n_tests++;
    if (first_ready != ST0 - 1) begin
      n_fail++;
      $display("FAIL clear_len: ready rose after %0d clk expected %0d", first_ready, ST0 - 1);
    end
    do_reset();
    for (int k = 0; k < ST0 - 1; k++) begin
      cyc(1'b0, 1'b1, W'($urandom), 1'b0);
      n_tests++;
      if (act_drop[0] !== RV0) begin
        n_fail++;
        $display("FAIL first_run tick%0d: drop=%h expected %h", k, act_drop[0], RV0);
      end
    end
  endtask

  task automatic test_ramp(input int period, input int ticks, input string name);
    do_reset();
    for (int k = 0; k < ticks; k++) begin
      for (int p = 0; p < period; p++) begin
        cyc(1'b0, (p == period - 1), (p == period - 1) ? W'(k) : W'($urandom), 1'b0);
        for (int i = 0; i < N; i++) begin
          n_tests++;
          if (act_drop[i] !== exp_drop[i]) begin
            n_fail++;
            $display("FAIL %s dut%0d tick%0d: drop=%h expected %h", name, i, k, act_drop[i], exp_drop[i]);
          end
        end
      end
      // Explicit latency: tick k emits the ramp value from tick k-(STAGES-1).
      if (k >= ST2 - 1) begin
        n_tests++;
        if (act_drop[2] !== W'(k - (ST2 - 1))) begin
          n_fail++;
          $display("FAIL %s_latency tick%0d: drop=%h expected %h", name, k, act_drop[2], W'(k - (ST2 - 1)));
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] want;
    do_reset();
    for (int k = 0; k < ST0 - 1; k++) cyc(1'b0, 1'b1, (k == 4) ? 5'h0A : 5'h00, 1'b0);
    for (int k = ST0 - 1; k < 4 * (ST0 - 1); k++) begin
      cyc(1'b0, 1'b1, 5'h03, 1'b1);
      want = ((k % (ST0 - 1)) == 4) ? 5'h0A : 5'h00;
      n_tests++;
      if (act_drop[0] !== want) begin
        n_fail++;
        $display("FAIL hold tick%0d: drop=%h expected %h", k, act_drop[0], want);
      end
      for (int i = 1; i < N; i++) begin
        n_tests++;
        if (act_drop[i] !== exp_drop[i]) begin
          n_fail++;
          $display("FAIL hold dut%0d tick%0d: drop=%h expected %h", i, k, act_drop[i], exp_drop[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    repeat (40) cyc(1'b0, 1'b1, W'($urandom), 1'($urandom));
    cyc(1'b1, 1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (act_drop[i] !== rstval[i] || act_ready[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_rst dut%0d: drop=%h ready=%b expected %h/0", i, act_drop[i], act_ready[i], rstval[i]);
      end
    end
    cyc(1'b1, 1'b1, W'($urandom), 1'b0);
    for (int j = 0; j < 40; j++) begin
      cyc(1'b0, 1'b1, W'($urandom), 1'b0);
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (act_drop[i] !== exp_drop[i] || act_ready[i] !== exp_ready[i]) begin
          n_fail++;
          $display("FAIL midrun dut%0d cyc%0d: drop=%h ready=%b expected %h/%b",
                   i, j, act_drop[i], act_ready[i], exp_drop[i], exp_ready[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      cyc(($urandom_range(63) == 0), 1'($urandom), W'($urandom), ($urandom_range(3) == 0));
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (act_drop[i] !== exp_drop[i] || act_ready[i] !== exp_ready[i]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: drop=%h ready=%b expected %h/%b",
                   i, j, act_drop[i], act_ready[i], exp_drop[i], exp_ready[i]);
        end
      end
    end
  endtask

  initial begin
    depth[0] = ST0 - 1;  rstval[0] = RV0;
    depth[1] = ST1 - 1;  rstval[1] = RV1;
    depth[2] = ST2 - 1;  rstval[2] = RV2;
    for (int i = 0; i < N; i++) begin
      run[i] = 1'b0; clr_cyc[i] = 0; tcnt[i] = 0;
      exp_drop[i] = rstval[i]; exp_ready[i] = 1'b0;
    end
    test_reset();
    test_clear_sweep();
    test_ramp(1, 60, "ramp");
    test_ramp(3, 50, "sparse");
    test_hold();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
